// File: rtl/vec_mem_arbiter.sv
// Two-port round-robin arbiter with burst locking for the single 16-bit memory port.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie and be exempt from the burst limit.
module vec_mem_arbiter #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic        Clk1,
   input  logic        Reset_n,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        Lock0,
   input  logic        Lock1,
   input  logic        Wr0,
   input  logic        Wr1,
   input  logic [15:0] Addr0,
   input  logic [15:0] Addr1,
   input  logic [15:0] WData0,
   input  logic [15:0] WData1,
   output logic        Gnt0,
   output logic        Gnt1,
   output logic        RValid0,
   output logic        RValid1,
   output logic [15:0] RData,
   output logic [15:0] Addr,
   output logic        RD,
   output logic        WR,
   output logic [15:0] dataOut,
   input  logic [15:0] DataIn
);

   localparam int unsigned BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);
   localparam logic [BW-1:0] BCNT_FULL = BW'(MAX_BURST);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          tag_valid_q, tag_valid_d;
   logic          tag_port_q, tag_port_d;

   logic acc0, acc1;
   logic limit0, limit1;

   function automatic logic [1:0] pick(input logic r0, input logic r1, input logic lst);
      logic [1:0] res;
      if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
         res = ST_OWN0;
`else
         res = lst ? ST_OWN0 : ST_OWN1;
`endif
      end else if (r0) begin
         res = ST_OWN0;
      end else if (r1) begin
         res = ST_OWN1;
      end else begin
         res = ST_IDLE;
      end
      return res;
   endfunction

   assign Gnt0 = (state_q == ST_OWN0);
   assign Gnt1 = (state_q == ST_OWN1);
   assign acc0 = Gnt0 & Req0;
   assign acc1 = Gnt1 & Req1;

   // >= rather than == so a count saturated during an uncontested lock still releases.
`ifdef ARB_FIXED_PRIO_EN
   assign limit0 = 1'b0;
`else
   assign limit0 = (bcnt_q >= BCNT_LAST) & acc0 & Req1;
`endif
   assign limit1 = (bcnt_q >= BCNT_LAST) & acc1 & Req0;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: state_d = pick(Req0, Req1, last_q);
         ST_OWN0: begin
            if (!(Req0 & Lock0 & ~limit0)) begin
               // Releasing owner counts as most recent, so the other port wins the tie now.
               state_d = pick(Req0, Req1, 1'b0);
               last_d  = 1'b0;
            end
         end
         ST_OWN1: begin
            if (!(Req1 & Lock1 & ~limit1)) begin
               state_d = pick(Req0, Req1, 1'b1);
               last_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bcnt_d = bcnt_q;
      if ((state_d != state_q) || (state_d == ST_IDLE)) begin
         bcnt_d = '0;
      end else if ((acc0 | acc1) && (bcnt_q != BCNT_FULL)) begin
         bcnt_d = bcnt_q + 1'b1;
      end
   end

   always_comb begin
      Addr    = '0;
      dataOut = '0;
      RD      = 1'b0;
      WR      = 1'b0;
      if (acc0) begin
         Addr    = Addr0;
         RD      = ~Wr0;
         WR      = Wr0;
         dataOut = Wr0 ? WData0 : '0;
      end else if (acc1) begin
         Addr    = Addr1;
         RD      = ~Wr1;
         WR      = Wr1;
         dataOut = Wr1 ? WData1 : '0;
      end
   end

   assign tag_valid_d = (acc0 & ~Wr0) | (acc1 & ~Wr1);
   assign tag_port_d  = acc1;

   always_ff @(posedge Clk1 or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         bcnt_q      <= '0;
         tag_valid_q <= 1'b0;
         tag_port_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         bcnt_q      <= bcnt_d;
         tag_valid_q <= tag_valid_d;
         tag_port_q  <= tag_port_d;
      end
   end

   assign RValid0 = tag_valid_q & ~tag_port_q;
   assign RValid1 = tag_valid_q & tag_port_q;
   assign RData   = tag_valid_q ? DataIn : '0;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed bench for vec_mem_arbiter: single reads, tie alternation, burst limit,
// write path, read-tag routing across handover, and asynchronous reset mid-burst.
module tb_vec_mem_arbiter;

   logic        Clk1;
   logic        Reset_n;
   logic        Req0, Req1, Lock0, Lock1, Wr0, Wr1;
   logic [15:0] Addr0, Addr1, WData0, WData1;
   logic        Gnt0, Gnt1, RValid0, RValid1;
   logic [15:0] RData, Addr, dataOut, DataIn;
   logic        RD, WR;

   int checks   = 0;
   int failures = 0;

   vec_mem_arbiter dut (
      .Clk1    (Clk1),
      .Reset_n (Reset_n),
      .Req0    (Req0),
      .Req1    (Req1),
      .Lock0   (Lock0),
      .Lock1   (Lock1),
      .Wr0     (Wr0),
      .Wr1     (Wr1),
      .Addr0   (Addr0),
      .Addr1   (Addr1),
      .WData0  (WData0),
      .WData1  (WData1),
      .Gnt0    (Gnt0),
      .Gnt1    (Gnt1),
      .RValid0 (RValid0),
      .RValid1 (RValid1),
      .RData   (RData),
      .Addr    (Addr),
      .RD      (RD),
      .WR      (WR),
      .dataOut (dataOut),
      .DataIn  (DataIn)
   );

   initial Clk1 = 1'b0;
   always #5 Clk1 = ~Clk1;

   task automatic tick();
      @(posedge Clk1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      Req0 = 0; Req1 = 0; Lock0 = 0; Lock1 = 0; Wr0 = 0; Wr1 = 0;
      Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0; DataIn = '0;

      // Reset values
      @(negedge Clk1);
      chk("rst_gnt0", {15'b0, Gnt0}, 16'd0);
      chk("rst_gnt1", {15'b0, Gnt1}, 16'd0);
      chk("rst_rvalid", {14'b0, RValid1, RValid0}, 16'd0);
      chk("rst_strobes", {14'b0, RD, WR}, 16'd0);
      chk("rst_addr", Addr, 16'h0000);
      chk("rst_dataout", dataOut, 16'h0000);
      chk("rst_rdata", RData, 16'h0000);
      @(posedge Clk1);
      #1;
      Reset_n = 1'b1;

      // Single read on port 0
      Req0 = 1; Wr0 = 0; Addr0 = 16'h0010;
      @(negedge Clk1);
      chk("t1_idle_gnt0", {15'b0, Gnt0}, 16'd0);
      tick();
      @(negedge Clk1);
      chk("t1_gnt0", {15'b0, Gnt0}, 16'd1);
      chk("t1_rd", {15'b0, RD}, 16'd1);
      chk("t1_wr", {15'b0, WR}, 16'd0);
      chk("t1_addr", Addr, 16'h0010);
      tick();
      Req0 = 0; DataIn = 16'hBEEF;
      @(negedge Clk1);
      chk("t1_rvalid0", {15'b0, RValid0}, 16'd1);
      chk("t1_rdata", RData, 16'hBEEF);
      chk("t1_rvalid1", {15'b0, RValid1}, 16'd0);
      chk("t1_no_strobe", {15'b0, RD}, 16'd0);
      tick();
      @(negedge Clk1);
      chk("t1_rvalid0_clr", {15'b0, RValid0}, 16'd0);
      chk("t1_idle", {14'b0, Gnt1, Gnt0}, 16'd0);

      // Both request single reads: last=0 now, so port 1 goes first, then alternate
      tick();
      Req0 = 1; Req1 = 1; Addr0 = 16'h0020; Addr1 = 16'h0030;
      @(negedge Clk1);
      chk("t2_idle", {14'b0, Gnt1, Gnt0}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge Clk1);
         if (i % 2 == 0) begin
            chk("t2_gnt", {14'b0, Gnt1, Gnt0}, 16'b10);
            chk("t2_addr", Addr, 16'h0030);
            chk("t2_rvalid", {14'b0, RValid1, RValid0}, (i == 0) ? 16'b00 : 16'b01);
         end else begin
            chk("t2_gnt", {14'b0, Gnt1, Gnt0}, 16'b01);
            chk("t2_addr", Addr, 16'h0020);
            chk("t2_rvalid", {14'b0, RValid1, RValid0}, 16'b10);
         end
         chk("t2_rd", {15'b0, RD}, 16'd1);
      end
      tick();
      Req0 = 0; Req1 = 0;
      @(negedge Clk1);
      chk("t2_tail_gnt1", {15'b0, Gnt1}, 16'd1);
      chk("t2_tail_rd", {15'b0, RD}, 16'd0);
      chk("t2_tail_rvalid0", {15'b0, RValid0}, 16'd1);
      tick();
      @(negedge Clk1);
      chk("t2_end_idle", {14'b0, Gnt1, Gnt0}, 16'd0);

      // Port 0 locked 16-word VLD while port 1 waits
      tick();
      Req0 = 1; Lock0 = 1; Wr0 = 0; Addr0 = 16'h0100;
      Req1 = 1; Wr1 = 0; Addr1 = 16'h0300;
      @(negedge Clk1);
      chk("t3_idle", {14'b0, Gnt1, Gnt0}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         Addr0 = 16'h0100 + 16'(i);
         @(negedge Clk1);
         chk("t3_burst_gnt", {14'b0, Gnt1, Gnt0}, 16'b01);
         chk("t3_burst_addr", Addr, 16'h0100 + 16'(i));
      end
      tick();
      Req0 = 0; Lock0 = 0;
      @(negedge Clk1);
      chk("t3_handover", {14'b0, Gnt1, Gnt0}, 16'b10);
      chk("t3_addr1", Addr, 16'h0300);
      chk("t3_last_rvalid0", {14'b0, RValid1, RValid0}, 16'b01);
      tick();
      Req1 = 0;
      @(negedge Clk1);
      chk("t3_rvalid1", {14'b0, RValid1, RValid0}, 16'b10);
      tick();
      @(negedge Clk1);
      chk("t3_end_idle", {14'b0, Gnt1, Gnt0}, 16'd0);

      // Port 1 locked writes, port 0 requesting: forced release after 16
      tick();
      Req1 = 1; Lock1 = 1; Wr1 = 1; Addr1 = 16'h0400; WData1 = 16'hA000;
      @(negedge Clk1);
      chk("t4_idle", {14'b0, Gnt1, Gnt0}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         Addr1 = 16'h0400 + 16'(i);
         WData1 = 16'hA000 + 16'(i);
         Req0 = 1; Wr0 = 0; Addr0 = 16'h0500;
         @(negedge Clk1);
         chk("t4_burst_gnt", {14'b0, Gnt1, Gnt0}, 16'b10);
         chk("t4_burst_wr", {14'b0, RD, WR}, 16'b01);
         chk("t4_burst_addr", Addr, 16'h0400 + 16'(i));
         chk("t4_burst_data", dataOut, 16'hA000 + 16'(i));
      end
      tick();
      @(negedge Clk1);
      chk("t4_release", {14'b0, Gnt1, Gnt0}, 16'b01);
      chk("t4_rd0", {14'b0, RD, WR}, 16'b10);
      chk("t4_addr0", Addr, 16'h0500);
      chk("t4_no_rvalid", {14'b0, RValid1, RValid0}, 16'd0);
      tick();
      Req0 = 0; Req1 = 0; Lock1 = 0;
      @(negedge Clk1);
      chk("t4_rvalid0", {14'b0, RValid1, RValid0}, 16'b01);
      tick();

      // Port 1 write, then read followed immediately by handover to port 0
      tick();
      Req1 = 1; Wr1 = 1; Addr1 = 16'h0200; WData1 = 16'h3C00;
      tick();
      @(negedge Clk1);
      chk("t5_gnt1", {14'b0, Gnt1, Gnt0}, 16'b10);
      chk("t5_wr", {14'b0, RD, WR}, 16'b01);
      chk("t5_dataout", dataOut, 16'h3C00);
      chk("t5_addr", Addr, 16'h0200);
      tick();
      Wr1 = 0; Addr1 = 16'h0210;
      Req0 = 1; Wr0 = 1; Addr0 = 16'h0220; WData0 = 16'h1111;
      @(negedge Clk1);
      chk("t5_no_rvalid_wr", {14'b0, RValid1, RValid0}, 16'd0);
      chk("t5_rd1", {14'b0, RD, WR}, 16'b10);
      chk("t5_rd1_addr", Addr, 16'h0210);
      chk("t5_rd1_dataout", dataOut, 16'h0000);
      tick();
      Req1 = 0; DataIn = 16'h5A5A;
      @(negedge Clk1);
      chk("t5_switch_gnt", {14'b0, Gnt1, Gnt0}, 16'b01);
      chk("t5_wr0_data", dataOut, 16'h1111);
      chk("t5_route_rvalid", {14'b0, RValid1, RValid0}, 16'b10);
      chk("t5_route_rdata", RData, 16'h5A5A);
      tick();
      Req0 = 0;
      @(negedge Clk1);
      chk("t5_wr0_no_rvalid", {14'b0, RValid1, RValid0}, 16'd0);
      tick();

      // Reset during transfer 5 of a locked burst
      tick();
      Req0 = 1; Lock0 = 1; Wr0 = 0; Addr0 = 16'h0700;
      for (int i = 0; i < 5; i++) begin
         tick();
         Addr0 = 16'h0700 + 16'(i);
         @(negedge Clk1);
         chk("t6_burst_gnt", {14'b0, Gnt1, Gnt0}, 16'b01);
         chk("t6_burst_addr", Addr, 16'h0700 + 16'(i));
      end
      chk("t6_pre_rvalid0", {15'b0, RValid0}, 16'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("t6_rst_gnt", {14'b0, Gnt1, Gnt0}, 16'd0);
      chk("t6_rst_strobes", {14'b0, RD, WR}, 16'd0);
      chk("t6_rst_rvalid", {14'b0, RValid1, RValid0}, 16'd0);
      chk("t6_rst_addr", Addr, 16'h0000);
      chk("t6_rst_rdata", RData, 16'h0000);
      @(posedge Clk1);
      #1;
      Reset_n = 1'b1;
      Lock0 = 0; Req0 = 1; Req1 = 1; Wr1 = 0; Addr0 = 16'h0800; Addr1 = 16'h0900;
      @(negedge Clk1);
      chk("t6_post_idle", {14'b0, Gnt1, Gnt0}, 16'd0);
      tick();
      @(negedge Clk1);
      chk("t6_tie_port0", {14'b0, Gnt1, Gnt0}, 16'b01);
      chk("t6_tie_addr", Addr, 16'h0800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
